// File: rtl/fp_pack_pkg.sv
// Shared types and constants for the floating-point adder final pack stage.
package fp_pack_pkg;

    localparam int GRS_W     = 3;
    localparam int W_EXP_MAX = 11;

    // Widest supported exponent; users slice it down to their own W_Exp.
    localparam logic [W_EXP_MAX-1:0] EXP_ALL_ONES = {W_EXP_MAX{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        ADJUST = 2'd2,
        PACK   = 2'd3
    } state_t;

endpackage

// File: rtl/final_result_pack_round_sgf.sv
// Significand rounding: increment decision and W_Sgf+1 adder.
// ROUND_RNE_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module round_sgf
    import fp_pack_pkg::*;
#(
    parameter int W_Sgf = 23
) (
    input  logic [W_Sgf-1:0] frac,
    input  logic [GRS_W-1:0] grs,
    output logic [W_Sgf:0]   sum,
    output logic             inexact
);

    logic inc;

`ifdef ROUND_RNE_EN
    assign inc = grs[2] & (grs[1] | grs[0] | frac[0]);
`else
    assign inc = 1'b0;
`endif

    assign sum     = {1'b0, frac} + {{W_Sgf{1'b0}}, inc};
    assign inexact = |grs;

endmodule

// File: rtl/final_result_pack.sv
// Final adder stage: rounds the significand, fixes the exponent on carry-out, packs the word.
// Rounding mode follows ROUND_RNE_EN (defined: nearest-even, undefined: truncate).
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// ROUND  | round the captured significand, register sum and inexact
// ADJUST | apply carry-out to exponent/fraction, detect post-round overflow
// PACK   | select infinity / signed zero / normal word, raise ready
module final_result_pack
    import fp_pack_pkg::*;
#(
    parameter int W_Exp = 8,
    parameter int W_Sgf = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sign_in,
    input  logic [W_Exp-1:0]         exp_in,
    input  logic                     overflow_in,
    input  logic                     underflow_in,
    input  logic [W_Sgf+GRS_W-1:0]   sgf_in,
    output logic                     busy,
    output logic                     ready,
    output logic [W_Exp+W_Sgf:0]     final_result,
    output logic                     overflow_flag,
    output logic                     underflow_flag,
    output logic                     inexact_flag
);

    localparam logic [W_Exp-1:0] EXP_MAX = EXP_ALL_ONES[W_Exp-1:0];

    state_t                   state_q;
    logic                     sign_q;
    logic [W_Exp-1:0]         exp_q;
    logic                     ovf_in_q;
    logic                     unf_in_q;
    logic [W_Sgf+GRS_W-1:0]   sgf_q;
    logic [W_Sgf:0]           sum_q;
    logic                     inexact_q;
    logic [W_Sgf-1:0]         frac_adj_q;
    logic [W_Exp-1:0]         exp_adj_q;
    logic                     ovf_round_q;

    logic [W_Sgf:0]           rnd_sum;
    logic                     rnd_inexact;
    logic [W_Exp-1:0]         exp_inc;

    round_sgf #(.W_Sgf(W_Sgf)) u_round_sgf (
        .frac    (sgf_q[W_Sgf+GRS_W-1:GRS_W]),
        .grs     (sgf_q[GRS_W-1:0]),
        .sum     (rnd_sum),
        .inexact (rnd_inexact)
    );

    assign exp_inc = exp_q + W_Exp'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            sign_q         <= 1'b0;
            exp_q          <= '0;
            ovf_in_q       <= 1'b0;
            unf_in_q       <= 1'b0;
            sgf_q          <= '0;
            sum_q          <= '0;
            inexact_q      <= 1'b0;
            frac_adj_q     <= '0;
            exp_adj_q      <= '0;
            ovf_round_q    <= 1'b0;
            busy           <= 1'b0;
            ready          <= 1'b0;
            final_result   <= '0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            inexact_flag   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q        <= ROUND;
                        sign_q         <= sign_in;
                        exp_q          <= exp_in;
                        ovf_in_q       <= overflow_in;
                        unf_in_q       <= underflow_in;
                        sgf_q          <= sgf_in;
                        busy           <= 1'b1;
                        ready          <= 1'b0;
                        overflow_flag  <= 1'b0;
                        underflow_flag <= 1'b0;
                        inexact_flag   <= 1'b0;
                    end
                end
                ROUND: begin
                    sum_q     <= rnd_sum;
                    inexact_q <= rnd_inexact;
                    state_q   <= ADJUST;
                end
                ADJUST: begin
                    // Carry-out means the significand rolled over to 10.000..., so bump the exponent.
                    if (sum_q[W_Sgf]) begin
                        frac_adj_q  <= '0;
                        exp_adj_q   <= exp_inc;
                        ovf_round_q <= (exp_inc == EXP_MAX);
                    end else begin
                        frac_adj_q  <= sum_q[W_Sgf-1:0];
                        exp_adj_q   <= exp_q;
                        ovf_round_q <= 1'b0;
                    end
                    state_q <= PACK;
                end
                PACK: begin
                    if (ovf_in_q || ovf_round_q) begin
                        final_result   <= {sign_q, EXP_MAX, {W_Sgf{1'b0}}};
                        overflow_flag  <= 1'b1;
                        underflow_flag <= 1'b0;
                        inexact_flag   <= 1'b1;
                    end else if (unf_in_q || (exp_q == '0)) begin
                        final_result   <= {sign_q, {W_Exp{1'b0}}, {W_Sgf{1'b0}}};
                        overflow_flag  <= 1'b0;
                        underflow_flag <= 1'b1;
                        inexact_flag   <= 1'b1;
                    end else begin
                        final_result   <= {sign_q, exp_adj_q, frac_adj_q};
                        overflow_flag  <= 1'b0;
                        underflow_flag <= 1'b0;
                        inexact_flag   <= inexact_q;
                    end
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_final_result_pack.sv
// Directed bench for final_result_pack (single precision); expectations follow ROUND_RNE_EN.
module tb_final_result_pack;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic        overflow_in;
    logic        underflow_in;
    logic [25:0] sgf_in;
    logic        busy;
    logic        ready;
    logic [31:0] final_result;
    logic        overflow_flag;
    logic        underflow_flag;
    logic        inexact_flag;

`ifdef ROUND_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    final_result_pack #(.W_Exp(8), .W_Sgf(23)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .sign_in        (sign_in),
        .exp_in         (exp_in),
        .overflow_in    (overflow_in),
        .underflow_in   (underflow_in),
        .sgf_in         (sgf_in),
        .busy           (busy),
        .ready          (ready),
        .final_result   (final_result),
        .overflow_flag  (overflow_flag),
        .underflow_flag (underflow_flag),
        .inexact_flag   (inexact_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request so it is sampled on the next rising edge, then scramble the inputs.
    task automatic capture(input logic s, input logic [7:0] e, input logic [22:0] f,
                           input logic [2:0] grs, input logic ov, input logic un);
        @(negedge clk);
        sign_in      = s;
        exp_in       = e;
        sgf_in       = {f, grs};
        overflow_in  = ov;
        underflow_in = un;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        sign_in      = ~s;
        exp_in       = 8'h55;
        sgf_in       = 26'h2AAAAAA;
        overflow_in  = ~ov;
        underflow_in = ~un;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (ready !== 1'b1 && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sign_in = 1'b0; exp_in = '0;
        overflow_in = 1'b0; underflow_in = 1'b0; sgf_in = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        total++; if (final_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", final_result); end
        total++; if ({overflow_flag, underflow_flag, inexact_flag} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {overflow_flag, underflow_flag, inexact_flag});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_one;
        int lat;
        capture(1'b0, 8'h7F, 23'h0, 3'b000, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL one_busy got=%b want=1", busy); end
        wait_ready(lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL one_latency got=%0d want=3", lat); end
        total++; if (final_result !== 32'h3F800000) begin bad++; $display("FAIL one_result got=%h want=3f800000", final_result); end
        total++; if ({overflow_flag, underflow_flag, inexact_flag} !== 3'b000) begin
            bad++; $display("FAIL one_flags got=%b want=000", {overflow_flag, underflow_flag, inexact_flag});
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL one_busy_done got=%b want=0", busy); end
    endtask

    task automatic test_tie_even;
        int lat;
        logic [31:0] want;
        capture(1'b0, 8'h7F, 23'h000001, 3'b100, 1'b0, 1'b0);
        wait_ready(lat);
        want = RNE ? 32'h3F800002 : 32'h3F800001;
        total++; if (final_result !== want) begin bad++; $display("FAIL tie_odd_result got=%h want=%h", final_result, want); end
        total++; if (inexact_flag !== 1'b1) begin bad++; $display("FAIL tie_odd_inexact got=%b want=1", inexact_flag); end
        capture(1'b0, 8'h7F, 23'h000002, 3'b100, 1'b0, 1'b0);
        wait_ready(lat);
        total++; if (final_result !== 32'h3F800002) begin bad++; $display("FAIL tie_even_result got=%h want=3f800002", final_result); end
        total++; if (inexact_flag !== 1'b1) begin bad++; $display("FAIL tie_even_inexact got=%b want=1", inexact_flag); end
    endtask

    task automatic test_carry;
        int lat;
        logic [31:0] want;
        capture(1'b0, 8'h7F, 23'h7FFFFF, 3'b110, 1'b0, 1'b0);
        wait_ready(lat);
        want = RNE ? 32'h40000000 : 32'h3FFFFFFF;
        total++; if (final_result !== want) begin bad++; $display("FAIL carry_result got=%h want=%h", final_result, want); end
        total++; if (inexact_flag !== 1'b1) begin bad++; $display("FAIL carry_inexact got=%b want=1", inexact_flag); end
        total++; if (overflow_flag !== 1'b0) begin bad++; $display("FAIL carry_overflow got=%b want=0", overflow_flag); end
    endtask

    task automatic test_post_ovf;
        int lat;
        logic [31:0] want;
        capture(1'b0, 8'hFE, 23'h7FFFFF, 3'b111, 1'b0, 1'b0);
        wait_ready(lat);
        want = RNE ? 32'h7F800000 : 32'h7F7FFFFF;
        total++; if (final_result !== want) begin bad++; $display("FAIL postovf_result got=%h want=%h", final_result, want); end
        total++; if (overflow_flag !== RNE) begin bad++; $display("FAIL postovf_flag got=%b want=%b", overflow_flag, RNE); end
        total++; if (inexact_flag !== 1'b1) begin bad++; $display("FAIL postovf_inexact got=%b want=1", inexact_flag); end
    endtask

    task automatic test_forced;
        int lat;
        capture(1'b1, 8'h80, 23'h123456, 3'b000, 1'b1, 1'b1);
        wait_ready(lat);
        total++; if (final_result !== 32'hFF800000) begin bad++; $display("FAIL forced_inf_result got=%h want=ff800000", final_result); end
        total++; if ({overflow_flag, underflow_flag, inexact_flag} !== 3'b101) begin
            bad++; $display("FAIL forced_inf_flags got=%b want=101", {overflow_flag, underflow_flag, inexact_flag});
        end
        capture(1'b1, 8'h80, 23'h123456, 3'b000, 1'b0, 1'b1);
        wait_ready(lat);
        total++; if (final_result !== 32'h80000000) begin bad++; $display("FAIL forced_zero_result got=%h want=80000000", final_result); end
        total++; if ({overflow_flag, underflow_flag, inexact_flag} !== 3'b011) begin
            bad++; $display("FAIL forced_zero_flags got=%b want=011", {overflow_flag, underflow_flag, inexact_flag});
        end
        capture(1'b0, 8'h00, 23'h000005, 3'b000, 1'b0, 1'b0);
        wait_ready(lat);
        total++; if (final_result !== 32'h00000000) begin bad++; $display("FAIL exp0_result got=%h want=00000000", final_result); end
        total++; if (underflow_flag !== 1'b1) begin bad++; $display("FAIL exp0_underflow got=%b want=1", underflow_flag); end
    endtask

    task automatic test_back_to_back;
        int lat;
        capture(1'b0, 8'h80, 23'h0, 3'b000, 1'b1, 1'b0);
        wait_ready(lat);
        // The next request is driven in the same cycle ready rose.
        capture(1'b0, 8'h81, 23'h200000, 3'b000, 1'b0, 1'b0);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_clear got=%b want=0", ready); end
        total++; if (overflow_flag !== 1'b0) begin bad++; $display("FAIL b2b_flag_clear got=%b want=0", overflow_flag); end
        total++; if (final_result !== 32'h7F800000) begin bad++; $display("FAIL b2b_result_hold got=%h want=7f800000", final_result); end
        wait_ready(lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL b2b_latency got=%0d want=3", lat); end
        total++; if (final_result !== 32'h40A00000) begin bad++; $display("FAIL b2b_result got=%h want=40a00000", final_result); end
    endtask

    task automatic test_start_ignored;
        int lat;
        capture(1'b0, 8'h7F, 23'h0, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        sign_in = 1'b1; exp_in = 8'h90; sgf_in = 26'h1234567; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_ready(lat);
        total++; if (final_result !== 32'h3F800000) begin bad++; $display("FAIL ignore_result got=%h want=3f800000", final_result); end
        repeat (5) @(negedge clk);
        total++; if (ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL ignore_idle got=ready%b/busy%b want=ready1/busy0", ready, busy);
        end
        total++; if (final_result !== 32'h3F800000) begin bad++; $display("FAIL ignore_hold got=%h want=3f800000", final_result); end
    endtask

    task automatic test_reset_mid;
        int lat;
        capture(1'b0, 8'h80, 23'h0, 3'b000, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        total++; if (ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_ctrl got=ready%b/busy%b want=ready0/busy0", ready, busy);
        end
        total++; if (final_result !== 32'h0) begin bad++; $display("FAIL midrst_result got=%h want=00000000", final_result); end
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b0 || final_result !== 32'h0) begin
            bad++; $display("FAIL midrst_partial got=ready%b/%h want=ready0/00000000", ready, final_result);
        end
        rst = 1'b1;
        capture(1'b1, 8'h81, 23'h400000, 3'b000, 1'b0, 1'b0);
        wait_ready(lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL midrst_latency got=%0d want=3", lat); end
        total++; if (final_result !== 32'hC0C00000) begin bad++; $display("FAIL midrst_result_after got=%h want=c0c00000", final_result); end
    endtask

    initial begin
        test_reset;
        test_one;
        test_tie_even;
        test_carry;
        test_post_ovf;
        test_forced;
        test_back_to_back;
        test_start_ignored;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
